trigonometry: RTL and testbench

TRIGONOMETRY -- requirements
Module: trigonometry

---
 rtl/trigonometry.sv | 104 ++++++++++
 tb/tb_trigonometry.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/trigonometry.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | trigonometry : registered sin/cos of a 32-bit binary angle, scale 1024,   |
// |                65-entry quarter-wave table. TRIG_ROUND_EN: round angle.   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module trigonometry (
  input  logic               i_clock,
  input  logic               i_RESET,
  input  logic signed [31:0] i_theta,
  output logic signed [31:0] o_cos,
  output logic signed [31:0] o_sin
);

  localparam logic signed [31:0] c_ONE = 32'sd1024;

  logic [7:0]         w_top;
  logic               w_unused;
  logic [1:0]         w_quad;
  logic [5:0]         w_idx;
  logic [10:0]        w_t_i;
  logic [10:0]        w_t_c;
  logic signed [31:0] w_pi;
  logic signed [31:0] w_pc;
  logic signed [31:0] w_ni;
  logic signed [31:0] w_nc;
  logic signed [31:0] w_sin;
  logic signed [31:0] w_cos;
  logic signed [31:0] r_sin;
  logic signed [31:0] r_cos;

  function automatic logic [10:0] f_tbl(input logic [6:0] k);
    case (k)
      7'd0:  f_tbl = 11'd0;    7'd1:  f_tbl = 11'd25;   7'd2:  f_tbl = 11'd50;
      7'd3:  f_tbl = 11'd75;   7'd4:  f_tbl = 11'd100;  7'd5:  f_tbl = 11'd125;
      7'd6:  f_tbl = 11'd150;  7'd7:  f_tbl = 11'd175;  7'd8:  f_tbl = 11'd200;
      7'd9:  f_tbl = 11'd224;  7'd10: f_tbl = 11'd249;  7'd11: f_tbl = 11'd273;
      7'd12: f_tbl = 11'd297;  7'd13: f_tbl = 11'd321;  7'd14: f_tbl = 11'd345;
      7'd15: f_tbl = 11'd369;  7'd16: f_tbl = 11'd392;  7'd17: f_tbl = 11'd415;
      7'd18: f_tbl = 11'd438;  7'd19: f_tbl = 11'd460;  7'd20: f_tbl = 11'd483;
      7'd21: f_tbl = 11'd505;  7'd22: f_tbl = 11'd526;  7'd23: f_tbl = 11'd548;
      7'd24: f_tbl = 11'd569;  7'd25: f_tbl = 11'd590;  7'd26: f_tbl = 11'd610;
      7'd27: f_tbl = 11'd630;  7'd28: f_tbl = 11'd650;  7'd29: f_tbl = 11'd669;
      7'd30: f_tbl = 11'd688;  7'd31: f_tbl = 11'd706;  7'd32: f_tbl = 11'd724;
      7'd33: f_tbl = 11'd742;  7'd34: f_tbl = 11'd759;  7'd35: f_tbl = 11'd775;
      7'd36: f_tbl = 11'd792;  7'd37: f_tbl = 11'd807;  7'd38: f_tbl = 11'd822;
      7'd39: f_tbl = 11'd837;  7'd40: f_tbl = 11'd851;  7'd41: f_tbl = 11'd865;
      7'd42: f_tbl = 11'd878;  7'd43: f_tbl = 11'd891;  7'd44: f_tbl = 11'd903;
      7'd45: f_tbl = 11'd915;  7'd46: f_tbl = 11'd926;  7'd47: f_tbl = 11'd936;
      7'd48: f_tbl = 11'd946;  7'd49: f_tbl = 11'd955;  7'd50: f_tbl = 11'd964;
      7'd51: f_tbl = 11'd972;  7'd52: f_tbl = 11'd980;  7'd53: f_tbl = 11'd987;
      7'd54: f_tbl = 11'd993;  7'd55: f_tbl = 11'd999;  7'd56: f_tbl = 11'd1004;
      7'd57: f_tbl = 11'd1009; 7'd58: f_tbl = 11'd1013; 7'd59: f_tbl = 11'd1016;
      7'd60: f_tbl = 11'd1019; 7'd61: f_tbl = 11'd1021; 7'd62: f_tbl = 11'd1023;
      7'd63: f_tbl = 11'd1024; 7'd64: f_tbl = 11'd1024;
      default: f_tbl = 11'd0;
    endcase
  endfunction

  // Only the top byte of the effective angle matters; rounding adds bit 23 into it.
`ifdef TRIG_ROUND_EN
  assign w_top    = i_theta[31:24] + {7'd0, i_theta[23]};
  assign w_unused = ^i_theta[22:0];
`else
  assign w_top    = i_theta[31:24];
  assign w_unused = ^i_theta[23:0];
`endif

  assign w_quad = w_top[7:6];
  assign w_idx  = w_top[5:0];
  assign w_t_i  = f_tbl({1'b0, w_idx});
  assign w_t_c  = f_tbl(7'd64 - {1'b0, w_idx});
  assign w_pi   = {21'd0, w_t_i};
  assign w_pc   = {21'd0, w_t_c};
  assign w_ni   = -w_pi;
  assign w_nc   = -w_pc;

  always_comb begin
    w_sin = w_pi;
    w_cos = w_pc;
    case (w_quad)
      2'd0: begin w_sin = w_pi; w_cos = w_pc; end
      2'd1: begin w_sin = w_pc; w_cos = w_ni; end
      2'd2: begin w_sin = w_ni; w_cos = w_nc; end
      2'd3: begin w_sin = w_nc; w_cos = w_pi; end
      default: begin w_sin = w_pi; w_cos = w_pc; end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_RESET) begin
      r_sin <= '0;
      r_cos <= c_ONE;
    end else begin
      r_sin <= w_sin;
      r_cos <= w_cos;
    end
  end

  assign o_sin = r_sin;
  assign o_cos = r_cos;

endmodule
`default_nettype wire

// File: tb/tb_trigonometry.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_trigonometry : self-checking bench for trigonometry, real-math model.  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_trigonometry;

  localparam real c_PI = 3.14159265358979323846;

  logic               clk;
  logic               rst_n;
  logic        [31:0] theta;
  logic signed [31:0] cos_o;
  logic signed [31:0] sin_o;

  int n_cmp;
  int n_err;

  trigonometry dut (
    .i_clock (clk),
    .i_RESET (rst_n),
    .i_theta (theta),
    .o_cos   (cos_o),
    .o_sin   (sin_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d (0x%08h) exp=%0d (0x%08h)", tag, $signed(got), got, $signed(exp), exp);
    end
  endtask

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else          return -$rtoi(-x + 0.5);
  endfunction

  // Effective table angle: top byte of the (optionally rounded) angle, 256 steps per turn.
  function automatic real eff_ang(input logic [31:0] th);
    logic [31:0] a;
    a = th;
`ifdef TRIG_ROUND_EN
    a = th + 32'h0080_0000;
`endif
    return 2.0 * c_PI * real'(a[31:24]) / 256.0;
  endfunction

  function automatic logic [31:0] ref_sin(input logic [31:0] th);
    return 32'(rnd(1024.0 * $sin(eff_ang(th))));
  endfunction

  function automatic logic [31:0] ref_cos(input logic [31:0] th);
    return 32'(rnd(1024.0 * $cos(eff_ang(th))));
  endfunction

  task automatic step(input logic [31:0] th);
    theta = th;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] d_th [7] = '{32'h0000_0000, 32'h2000_0000, 32'h4000_0000, 32'h8000_0000,
                            32'hC000_0000, 32'h00FF_FFFF, 32'hFFFF_FFFF};
`ifdef TRIG_ROUND_EN
  int d_s [7] = '{0, 724, 1024, 0, -1024, 25, 0};
`else
  int d_s [7] = '{0, 724, 1024, 0, -1024, 0, -25};
`endif
  int d_c [7] = '{1024, 724, 0, -1024, 0, 1024, 1024};

  int          s_arr [256];
  int          c_arr [256];
  logic [31:0] prev;
  logic [31:0] nxt;
  logic [23:0] lo;
  int          e;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    theta = 32'h4000_0000;
    @(posedge clk); #1;
    check_val("rst_sin", sin_o, 32'd0);
    check_val("rst_cos", cos_o, 32'd1024);

    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step(d_th[i]);
      check_val($sformatf("dir_sin[%08h]", d_th[i]), sin_o, 32'(d_s[i]));
      check_val($sformatf("dir_cos[%08h]", d_th[i]), cos_o, 32'(d_c[i]));
    end

    step(32'h4000_0000);
    check_val("mid_pre_sin", sin_o, 32'd1024);
    rst_n = 1'b0;
    step(32'h4000_0000);
    check_val("mid_rst_sin", sin_o, 32'd0);
    check_val("mid_rst_cos", cos_o, 32'd1024);
    rst_n = 1'b1;
    theta = 32'h8000_0000;
    #1;
    check_val("rel_hold_cos", cos_o, 32'd1024);
    @(posedge clk); #1;
    check_val("rel_cos", cos_o, 32'hFFFF_FC00);
    check_val("rel_sin", sin_o, 32'd0);

    for (int j = 0; j < 256; j++) begin
      step({j[7:0], 24'h0});
      s_arr[j] = sin_o;
      c_arr[j] = cos_o;
      check_val($sformatf("sweep_sin[%0d]", j), sin_o, ref_sin({j[7:0], 24'h0}));
      check_val($sformatf("sweep_cos[%0d]", j), cos_o, ref_cos({j[7:0], 24'h0}));
    end
    for (int j = 0; j < 256; j++) begin
      e = s_arr[j] * s_arr[j] + c_arr[j] * c_arr[j] - 1048576;
      check_val($sformatf("energy[%0d]", j), 32'((e <= 2100 && e >= -2100) ? 1 : 0), 32'd1);
      check_val($sformatf("odd_sin[%0d]", j), 32'(s_arr[(256 - j) % 256]), 32'(-s_arr[j]));
      check_val($sformatf("even_cos[%0d]", j), 32'(c_arr[(256 - j) % 256]), 32'(c_arr[j]));
    end

    prev = {8'd255, 24'h0};
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(4))
        0: lo = 24'h00_0000;
        1: lo = 24'h7F_FFFF;
        2: lo = 24'h80_0000;
        3: lo = 24'hFF_FFFF;
        default: lo = 24'($urandom);
      endcase
      nxt = {8'($urandom), lo};
      theta = nxt;
      #1;
      check_val("hold_sin", sin_o, ref_sin(prev));
      check_val("hold_cos", cos_o, ref_cos(prev));
      @(posedge clk); #1;
      check_val($sformatf("rand_sin[%08h]", nxt), sin_o, ref_sin(nxt));
      check_val($sformatf("rand_cos[%08h]", nxt), cos_o, ref_cos(nxt));
      prev = nxt;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
